// File: rtl/apb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apb_pkg                                                |
// | Description : Shared types and constants for the APB register slave. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package apb_pkg;

  // Handshake states of the completer
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } apb_slv_state_e;

  // Byte address bit where the word index begins
  localparam int APB_WORD_LSB = 2;

  // Wait-state counter width (covers 0..15)
  localparam int WAIT_CNT_W = 4;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apb_reg_bank                                           |
// | Description : Software-visible register array with a synchronous     |
// |               write port, one-cycle write strobes and a              |
// |               combinational read port. Unmapped indices read as 0.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NR_REGS    = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_we,
  input  logic [ADDR_WIDTH-APB_WORD_LSB-1:0] i_widx,
  input  logic [DATA_WIDTH-1:0]              i_wdata,
  input  logic [ADDR_WIDTH-APB_WORD_LSB-1:0] i_ridx,
  output logic [DATA_WIDTH-1:0]              o_rdata,
  output logic [NR_REGS*DATA_WIDTH-1:0]      o_regs_q,
  output logic [NR_REGS-1:0]                 o_wr_strobe
);

  logic [DATA_WIDTH-1:0] r_regs [NR_REGS];
  logic [NR_REGS-1:0]    r_strobe;
  logic [NR_REGS-1:0]    w_wr_hit;

  // Per-register write decode; an out-of-range index hits nothing
  always_comb begin
    w_wr_hit = '0;
    for (int i = 0; i < NR_REGS; i++) begin
      w_wr_hit[i] = i_we && (32'(i_widx) == 32'(i));
    end
  end

  // Register storage: only the decoded register takes the write data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NR_REGS; i++) begin
        r_regs[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < NR_REGS; i++) begin
        if (w_wr_hit[i]) begin
          r_regs[i] <= i_wdata;
        end
      end
    end
  end

  // Strobe is the write decode delayed one cycle, so it lines up with the new value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_strobe <= '0;
    end else begin
      r_strobe <= w_wr_hit;
    end
  end

  // Combinational read; unmapped indices fall through to zero
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < NR_REGS; i++) begin
      if (32'(i_ridx) == 32'(i)) begin
        o_rdata = r_regs[i];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NR_REGS; gi++) begin : g_regs_q
      assign o_regs_q[gi*DATA_WIDTH +: DATA_WIDTH] = r_regs[gi];
    end
  endgenerate

  assign o_wr_strobe = r_strobe;

endmodule : apb_reg_bank
`default_nettype wire

// File: rtl/apb_reg_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : apb_reg_slave                                          |
// | Description : APB completer terminating sel/addr/wr_rd/wdata into a  |
// |               register bank, answering with a one-cycle ready pulse  |
// |               after WAIT_STATES idle cycles.                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 5,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NR_REGS     = 8,
  parameter int                    WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sel,
  input  logic [ADDR_WIDTH-1:0]         addr,
  input  logic                          wr_rd,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          ready,
  output logic [NR_REGS*DATA_WIDTH-1:0] regs_q,
  output logic [NR_REGS-1:0]            wr_strobe
);

  localparam int IDX_W = ADDR_WIDTH - APB_WORD_LSB;

  apb_slv_state_e          r_state;
  apb_slv_state_e          w_state_nxt;
  logic [WAIT_CNT_W-1:0]   r_cnt;
  logic [WAIT_CNT_W-1:0]   w_cnt_nxt;
  logic                    r_wr;
  logic [DATA_WIDTH-1:0]   r_rd_latch;
  logic                    w_setup;
  logic                    w_we;
  logic [IDX_W-1:0]        w_idx;
  logic [DATA_WIDTH-1:0]   w_bank_rdata;
  logic                    w_unused;

  // Byte-lane bits carry no meaning for word registers
  assign w_unused = ^addr[APB_WORD_LSB-1:0];

  assign w_idx   = addr[ADDR_WIDTH-1:APB_WORD_LSB];
  assign w_setup = (r_state == IDLE) && sel;
  // Writes commit on the setup edge itself, so later bus changes cannot affect them
  assign w_we    = w_setup && wr_rd;

  apb_reg_bank #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NR_REGS    (NR_REGS),
    .RESET_VAL  (RESET_VAL)
  ) u_bank (
    .clk         (clk),
    .rst         (rst),
    .i_we        (w_we),
    .i_widx      (w_idx),
    .i_wdata     (wdata),
    .i_ridx      (w_idx),
    .o_rdata     (w_bank_rdata),
    .o_regs_q    (regs_q),
    .o_wr_strobe (wr_strobe)
  );

  // State and wait counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture direction and read data at the setup edge; writes latch zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr       <= 1'b0;
      r_rd_latch <= '0;
    end else if (w_setup) begin
      r_wr       <= wr_rd;
      r_rd_latch <= wr_rd ? '0 : w_bank_rdata;
    end
  end

  // Next-state and counter logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (sel) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt = ACK;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = WAIT_CNT_W'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (!sel) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt <= WAIT_CNT_W'(1)) begin
          w_state_nxt = ACK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt - WAIT_CNT_W'(1);
        end
      end
      ACK: begin
        w_state_nxt = sel ? DONE : IDLE;
      end
      DONE: begin
        if (!sel) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: rdata is forced to zero outside ACK so the bus can be OR-muxed
  always_comb begin
    ready = 1'b0;
    rdata = '0;
    if (r_state == ACK) begin
      ready = 1'b1;
      rdata = r_wr ? '0 : r_rd_latch;
    end
  end

endmodule : apb_reg_slave
`default_nettype wire
